pipe_stage_fd: RTL
==================

# pipe_stage_fd

Parametrised fetch-to-decode pipeline stage register with a valid/ready handshake on both sides, a synchronous flush, and an optional 2-entry skid buffer. It sits between the fetch stage and the decode stage and carries the instruction word and its PC. It replaces the bare enable-gated instruction register: stalls come from `out_ready` back-pressure, bubbles are explicit `out_valid=0` cycles driving a NOP payload, and branch mispredicts use `flush`.

## Interface
- `INSTR_W`, default 32: instruction width.
- `PC_W`, default 32: PC width.
- `NOP`, default `32'h0000_0000`: payload driven on `out_instr` whenever `out_valid=0`.
- `SKID`, default 1: 1 selects a 2-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous kill of all held entries.
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: stage can accept.
- `in_instr` in INSTR_W: fetched instruction.
- `in_pc` in PC_W: PC of `in_instr`.
- `out_valid` out 1: decode entry valid.
- `out_ready` in 1: decode consumes; low means stall.
- `out_instr` out INSTR_W: instruction to decode.
- `out_pc` out PC_W: PC to decode.
- `occupancy` out 2: number of valid entries (0..2).

## Operation
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Entries:
  - Main entry M drives the outputs.
  - Skid entry S exists only when `SKID=1`.
- `SKID=1`:
  - `in_ready = !S.valid`, purely from a register.
  - If `!M.valid | out_fire`: M loads S when S is valid (S then takes `in_fire` data if any, else clears). Otherwise M loads the input on `in_fire`, or clears.
  - If `M.valid & !out_ready` and `in_fire`: the input goes to S.
  - Order is strictly FIFO. No beat is dropped or duplicated.
- `SKID=0`:
  - `in_ready = !M.valid | out_ready`.
  - M loads on `in_fire`, else clears on `out_fire`.
- Flush has the highest priority:
  - M and S valid bits clear.
  - An `in_fire` in the same cycle is discarded.
  - `out_fire` in the flush cycle still counts; decode sees that beat once.
- Whenever an entry is invalid, `out_instr = NOP` and `out_pc = 0`. Payload registers load NOP and 0 on clear, so decode never sees stale data.
- `occupancy = M.valid + S.valid`.
- Hold: when `M.valid & !out_ready`, `out_instr` and `out_pc` stay bit-stable.

## Timing
- Reset (async assert, released synchronously by the system):
  - `out_valid=0`, `out_instr=NOP`, `out_pc=0`, `occupancy=0`.
  - `in_ready=1` both during and after reset.
- Latency: `in_fire` in cycle N gives `out_valid=1` with that data in cycle N+1 when the stage was empty or draining.
- Throughput: 1 beat/cycle sustained when `out_ready=1`.
- `SKID=1`: no combinational path from `out_ready` to `in_ready`. `in_ready` falls the cycle after S fills and rises the cycle after S drains.
- Flush asserted in cycle N gives `out_valid=0`, `occupancy=0`, `in_ready=1` in N+1.
- Reset asserted mid-transfer forces the reset values immediately, independent of the clock.

## Structure
- Shared package `pipe_pkg` holds:
  - Default `NOP` constant.
  - Default widths.
  - The `fd_payload_t` struct (instr, pc).
- Sub-module `pipe_slot` holds one valid+payload entry with load/clear controls. It is instantiated as M always, and as S under `generate` when `SKID=1`.
- The top level holds only handshake and steering logic.

## Test plan
- Reset: assert `rst_n=0` mid-cycle → immediately `out_valid=0`, `out_instr=0x00000000`, `occupancy=0`, `in_ready=1`.
- Streaming: feed instr `0x20080001..0x20080008` with PCs `0x0..0x1C` back-to-back, `out_ready=1` → identical sequence out one cycle later, no gaps.
- Stall with `SKID=1`: drop `out_ready` for 3 cycles while `in_valid=1` → S captures the second beat, `occupancy=2`, `in_ready=0` from the next cycle, `out_instr` stable. On release, order is preserved.
- Flush: with `occupancy=2`, assert `flush` with `in_valid=1` (instr `0xDEADBEEF`) → next cycle `out_valid=0`, `occupancy=0`, and `0xDEADBEEF` never appears at the output.
- Random: `SKID=0` and `SKID=1` under random `in_valid`/`out_ready`/rare `flush` for 10k cycles → scoreboard shows exact FIFO order, no loss or duplication except flushed beats, and `out_instr=NOP` whenever `out_valid=0`.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch-to-decode pipeline stage: default widths,
// the default bubble payload and the instruction/PC bus payload.
package pipe_pkg;

  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned PC_W_DEF    = 32;

  localparam logic [INSTR_W_DEF-1:0] NOP_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc;
  } fd_payload_t;

  // Number of valid entries held by the stage (0..2).
  function automatic logic [1:0] occ_count(input logic m_valid, input logic s_valid);
    return 2'(m_valid) + 2'(s_valid);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: a valid bit plus payload. Load wins over clear; a cleared
// entry parks its payload at CLR_VAL so downstream never observes stale data.
module pipe_slot #(
  parameter int unsigned   W       = 64,
  parameter logic [W-1:0]  CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= CLR_VAL;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= CLR_VAL;
    end
  end

endmodule

// File: rtl/pipe_stage_fd.sv
// Fetch-to-decode stage register with valid/ready on both sides, synchronous
// flush and an optional skid entry that decouples in_ready from out_ready.
module pipe_stage_fd
  import pipe_pkg::*;
#(
  parameter int unsigned          INSTR_W = INSTR_W_DEF,
  parameter int unsigned          PC_W    = PC_W_DEF,
  parameter logic [INSTR_W-1:0]   NOP     = INSTR_W'(NOP_DEF),
  parameter bit                   SKID    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [1:0]         occupancy
);

  localparam int unsigned     PW  = INSTR_W + PC_W;
  localparam logic [PW-1:0]   CLR = {NOP, {PC_W{1'b0}}};

  logic [PW-1:0] in_pl;
  logic [PW-1:0] m_d;
  logic [PW-1:0] m_q;
  logic [PW-1:0] s_q;
  logic          m_v;
  logic          s_v;
  logic          m_load;
  logic          m_clear;
  logic          s_load;
  logic          s_clear;
  logic          in_fire;
  logic          out_fire;

  assign in_pl    = {in_instr, in_pc};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_v & out_ready;

  // Steering: flush kills everything; otherwise S drains into M before any new beat.
  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    m_d     = in_pl;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else if (SKID) begin
      if (!m_v || out_fire) begin
        if (s_v) begin
          m_load = 1'b1;
          m_d    = s_q;
          if (in_fire) s_load  = 1'b1;
          else         s_clear = 1'b1;
        end else if (in_fire) begin
          m_load = 1'b1;
        end else begin
          m_clear = 1'b1;
        end
      end else if (in_fire) begin
        s_load = 1'b1;
      end
    end else begin
      if (in_fire)       m_load  = 1'b1;
      else if (out_fire) m_clear = 1'b1;
    end
  end

  pipe_slot #(
    .W       (PW),
    .CLR_VAL (CLR)
  ) u_m (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (m_load),
    .clear (m_clear),
    .d     (m_d),
    .valid (m_v),
    .q     (m_q)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(
        .W       (PW),
        .CLR_VAL (CLR)
      ) u_s (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (s_load),
        .clear (s_clear),
        .d     (in_pl),
        .valid (s_v),
        .q     (s_q)
      );
      // Registered ready: depends only on the skid valid flop.
      assign in_ready = ~s_v;
    end else begin : g_noskid
      logic unused_s;
      assign unused_s = s_load ^ s_clear;
      assign s_v      = 1'b0;
      assign s_q      = CLR;
      assign in_ready = ~m_v | out_ready;
    end
  endgenerate

  assign out_valid = m_v;
  assign out_instr = m_q[PW-1:PC_W];
  assign out_pc    = m_q[PC_W-1:0];
  assign occupancy = occ_count(m_v, s_v);

endmodule
